// File: rtl/mcx_pkg.sv
// Shared definitions for the MCX program loader: geometry, frame header,
// line field positions, loader state encoding and small helpers.
package mcx_pkg;

  localparam int LINE_W = 46;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Instruction line field positions
  localparam int PC_MSB   = 45;
  localparam int PC_LSB   = 42;
  localparam int COND_MSB = 41;
  localparam int COND_LSB = 40;
  localparam int INST_MSB = 39;
  localparam int INST_LSB = 36;
  localparam int ARG0_MSB = 35;
  localparam int ARG0_LSB = 24;
  localparam int ARG1_MSB = 23;
  localparam int ARG1_LSB = 12;
  localparam int ARG2_MSB = 11;
  localparam int ARG2_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    COMMIT = 3'd4
  } ld_state_e;

  // A frame carries between 1 and DEPTH lines
  function automatic logic count_ok(input logic [7:0] n);
    return (n >= 8'd1) && (n <= 8'd16);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: byte stream in, fetch read port, core control/status out.
interface prog_loader_if;
  import mcx_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] line;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  // Loader side
  modport slave (
    input  in_data, in_valid, addr,
    output in_ready, line, core_hold, load_done, load_err
  );

  // Host / core side
  modport master (
    output in_data, in_valid, addr,
    input  in_ready, line, core_hold, load_done, load_err
  );

endinterface

// File: rtl/prog_ram.sv
// Program store: DEPTH x LINE_W, synchronous write, asynchronous read.
// Contents are deliberately not reset; visibility is gated by the loader.
module prog_ram
  import mcx_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  // Line write on commit of each assembled line
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// MCX program loader: receives framed byte stream (header, count, N lines of
// 6 bytes, optional checksum), writes lines into the program store and holds
// the core in reset until a complete, valid program is committed.
// Optional build macro LOADER_CKSUM_EN adds the trailing XOR checksum byte.
module prog_loader
  import mcx_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  // Only the low 38 bits of the first five bytes are kept: the top two bits
  // of the first byte fall off the shift register, which is the line mask.
  logic [37:0]       asm_q, asm_d;
  logic [CNT_W-1:0]  lines_loaded_q, lines_loaded_d;
  logic              core_hold_q, core_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic              in_ready_s;
  logic              xfer_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [LINE_W-1:0] wdata_s;
  logic [LINE_W-1:0] rdata_s;

  assign in_ready_s = (state_q != COMMIT);
  assign xfer_s     = bus.in_valid && in_ready_s;

  // Next-state, assembly, counters and memory write control
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    line_cnt_d     = line_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    lines_loaded_d = lines_loaded_q;
    core_hold_d    = core_hold_q;
    load_done_d    = 1'b0;
    load_err_d     = load_err_q;
`ifdef LOADER_CKSUM_EN
    acc_d          = acc_q;
`endif
    we_s           = 1'b0;
    waddr_s        = line_cnt_q[ADDR_W-1:0];
    wdata_s        = {asm_q, bus.in_data};

    case (state_q)
      IDLE: begin
        if (xfer_s && (bus.in_data == HDR_BYTE)) begin
          state_d        = COUNT;
          load_err_d     = 1'b0;
          lines_loaded_d = 5'd0;
          core_hold_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (xfer_s) begin
          if (count_ok(bus.in_data)) begin
            n_d        = bus.in_data[CNT_W-1:0];
            line_cnt_d = 5'd0;
            byte_cnt_d = 3'd0;
`ifdef LOADER_CKSUM_EN
            acc_d      = 8'd0;
`endif
            state_d    = DATA;
          end else begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          state_d = COUNT;
        end
      end
      DATA: begin
        if (xfer_s) begin
          asm_d = {asm_q[29:0], bus.in_data};
`ifdef LOADER_CKSUM_EN
          acc_d = acc_q ^ bus.in_data;
`endif
          if (byte_cnt_q == 3'd5) begin
            byte_cnt_d = 3'd0;
            we_s       = 1'b1;
            line_cnt_d = line_cnt_q + 5'd1;
            if ((line_cnt_q + 5'd1) == n_q) begin
`ifdef LOADER_CKSUM_EN
              state_d = CHECK;
`else
              state_d = COMMIT;
`endif
            end else begin
              state_d = DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
`ifdef LOADER_CKSUM_EN
        if (xfer_s) begin
          if (bus.in_data == acc_q) begin
            state_d = COMMIT;
          end else begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          state_d = CHECK;
        end
`else
        state_d = IDLE;
`endif
      end
      COMMIT: begin
        lines_loaded_d = n_q;
        load_done_d    = 1'b1;
        core_hold_d    = 1'b0;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any concurrent transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= 5'd0;
      line_cnt_q     <= 5'd0;
      byte_cnt_q     <= 3'd0;
      asm_q          <= 38'd0;
      lines_loaded_q <= 5'd0;
      core_hold_q    <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
`ifdef LOADER_CKSUM_EN
      acc_q          <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      line_cnt_q     <= line_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      lines_loaded_q <= lines_loaded_d;
      core_hold_q    <= core_hold_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
`ifdef LOADER_CKSUM_EN
      acc_q          <= acc_d;
`endif
    end
  end

  prog_ram u_ram (
    .clk_i   (clk),
    .we_i    (we_s && !rst),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (bus.addr),
    .rdata_o (rdata_s)
  );

  // Lines beyond the committed count read as zero
  assign bus.line      = ({1'b0, bus.addr} < lines_loaded_q) ? rdata_s : {LINE_W{1'b0}};
  assign bus.in_ready  = in_ready_s;
  assign bus.core_hold = core_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader. Frames carry a checksum byte
// only when LOADER_CKSUM_EN is defined, matching the build under test.
module tb_prog_loader;
  import mcx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  prog_loader_if bus ();

  prog_loader u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int d0;
  logic [47:0] fl [16];

  // Count load_done pulses seen at clock edges
  always @(posedge clk) begin
    if (bus.load_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_line(input string tag, input logic [3:0] a, input logic [45:0] exp);
    bus.addr = a;
    #1;
    check_eq(tag, {18'd0, bus.line}, {18'd0, exp});
  endtask

  // Drive one byte; optional idle cycle first. Returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    waited = 0;
    if (gap) @(posedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check_eq("rdy_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap, input bit bad_ck);
    logic [7:0] ck;
    ck = 8'd0;
    send_byte(HDR_BYTE, 1'b0);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 6; k++) begin
        send_byte(fl[i][47-8*k -: 8], gap);
        ck = ck ^ fl[i][47-8*k -: 8];
      end
    end
`ifdef LOADER_CKSUM_EN
    send_byte(ck ^ {7'd0, bad_ck}, gap);
`else
    if (bad_ck) ck = ~ck;
`endif
  endtask

  // Checks around a successful commit: COMMIT cycle, then the pulse
  task automatic check_commit(input string tag);
    @(negedge clk);
    check_eq({tag, "_rdy_commit"}, {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, {63'd0, bus.load_done}, 64'd1);
    check_eq({tag, "_hold"}, {63'd0, bus.core_hold}, 64'd0);
    check_eq({tag, "_rdy_after"}, {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    check_eq({tag, "_done_low"}, {63'd0, bus.load_done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_data = 8'd0;
    bus.in_valid = 1'b0;
    bus.addr = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_hold", {63'd0, bus.core_hold}, 64'd1);
    check_eq("rst_err", {63'd0, bus.load_err}, 64'd0);
    check_eq("rst_done", {63'd0, bus.load_done}, 64'd0);
    check_eq("rst_rdy", {63'd0, bus.in_ready}, 64'd1);
    check_line("rst_line0", 4'd0, 46'd0);
    check_line("rst_line15", 4'd15, 46'd0);

    // Non-header bytes dropped in IDLE
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    @(negedge clk);
    check_eq("drop_hold", {63'd0, bus.core_hold}, 64'd1);
    check_eq("drop_rdy", {63'd0, bus.in_ready}, 64'd1);

    // Two-line frame from the reference example
    fl[0] = 48'h0000_0000_0001;
    fl[1] = 48'h3FFF_FFFF_FFFF;
    d0 = done_cnt;
    send_frame(2, 1'b0, 1'b0);
    check_commit("f2");
    check_eq("f2_pulses", 64'(done_cnt - d0), 64'd1);
    check_line("f2_l0", 4'd0, 46'h0000_0000_0001);
    check_line("f2_l1", 4'd1, 46'h3FFF_FFFF_FFFF);
    check_line("f2_l5", 4'd5, 46'd0);
    check_eq("f2_err", {63'd0, bus.load_err}, 64'd0);

`ifdef LOADER_CKSUM_EN
    // Corrupted checksum, then recovery with a good frame
    send_frame(2, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("ck_err", {63'd0, bus.load_err}, 64'd1);
    check_eq("ck_hold", {63'd0, bus.core_hold}, 64'd1);
    check_line("ck_l0", 4'd0, 46'd0);
    d0 = done_cnt;
    send_frame(2, 1'b0, 1'b0);
    check_commit("ckok");
    check_eq("ckok_err", {63'd0, bus.load_err}, 64'd0);
    check_eq("ckok_pulses", 64'(done_cnt - d0), 64'd1);
`endif

    // Illegal counts 0 and 17
    send_byte(HDR_BYTE, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check_eq("cnt0_err", {63'd0, bus.load_err}, 64'd1);
    check_eq("cnt0_hold", {63'd0, bus.core_hold}, 64'd1);
    check_eq("cnt0_rdy", {63'd0, bus.in_ready}, 64'd1);
    check_line("cnt0_l0", 4'd0, 46'd0);
    send_byte(HDR_BYTE, 1'b0);
    @(negedge clk);
    check_eq("hdr_clr_err", {63'd0, bus.load_err}, 64'd0);
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    check_eq("cnt17_err", {63'd0, bus.load_err}, 64'd1);

    // Three lines with in_valid toggled every other cycle
    fl[0] = 48'h1234_5678_9ABC;
    fl[1] = 48'hFEDC_BA98_7654;
    fl[2] = 48'h00FF_00FF_00FF;
    d0 = done_cnt;
    send_frame(3, 1'b1, 1'b0);
    check_commit("gap");
    check_eq("gap_pulses", 64'(done_cnt - d0), 64'd1);
    check_eq("gap_err", {63'd0, bus.load_err}, 64'd0);
    check_line("gap_l0", 4'd0, 46'h1234_5678_9ABC);
    check_line("gap_l1", 4'd1, 46'h3EDC_BA98_7654);
    check_line("gap_l2", 4'd2, 46'h00FF_00FF_00FF);
    check_line("gap_l3", 4'd3, 46'd0);

    // New header while running re-asserts hold at once
    send_byte(HDR_BYTE, 1'b0);
    @(negedge clk);
    check_eq("rehdr_hold", {63'd0, bus.core_hold}, 64'd1);
    check_line("rehdr_l0", 4'd0, 46'd0);

    // Reset after the third line byte abandons the frame
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_hold", {63'd0, bus.core_hold}, 64'd1);
    check_eq("mid_err", {63'd0, bus.load_err}, 64'd0);
    check_eq("mid_rdy", {63'd0, bus.in_ready}, 64'd1);
    check_line("mid_l0", 4'd0, 46'd0);

    // Full 16-line frame
    for (int i = 0; i < 16; i++) begin
      fl[i] = {8'hC0 + 8'(i), 8'(8'h11 * i), 32'hDEAD_0000 + 32'(i)};
    end
    d0 = done_cnt;
    send_frame(16, 1'b0, 1'b0);
    check_commit("f16");
    check_eq("f16_pulses", 64'(done_cnt - d0), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check_line($sformatf("f16_l%0d", i), 4'(i), fl[i][45:0]);
    end
    check_line("f16_l15_hand", 4'd15, 46'h0FFF_DEAD_000F);
    check_line("f16_l0_hand", 4'd0, 46'h0000_DEAD_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
